param_mem: RTL and testbench
============================

PARAM_MEM -- requirements
Module: param_mem

Interface
REQ-001 Parameter DATA_W, default 32: word width in bits; SHALL be a multiple of 8, range 8..128.
REQ-002 Parameter DEPTH, default 48: number of words; need not be a power of two.
REQ-003 Parameter ADDR_W, default $clog2(DEPTH): request address width.
REQ-004 Parameter RD_LAT, default 2: read latency in cycles, range 1..4.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 req_valid  input  1  request present.
REQ-008 req_ready  output  1  block can accept a request this cycle.
REQ-009 req_wr  input  1  1 = write, 0 = read.
REQ-010 req_addr  input  ADDR_W  word address.
REQ-011 req_wdata  input  DATA_W  write data.
REQ-012 req_be  input  DATA_W/8  byte enables; bit i enables byte i.
REQ-013 rsp_valid  output  1  read response present; single-cycle pulse per read.
REQ-014 rsp_rdata  output  DATA_W  read data, valid only with rsp_valid.
REQ-015 rsp_err  output  1  read address out of range, valid only with rsp_valid.
REQ-016 clr_start  input  1  request a full-array clear.
REQ-017 clr_busy  output  1  clear engine active.
REQ-018 err_cnt  output  8  saturating count of out-of-range requests.

Function
REQ-019 A request is accepted when req_valid and req_ready are both 1 on a rising edge; at most one request is accepted per cycle.
REQ-020 The control FSM has two states: INIT and IDLE; req_ready is 1 only in IDLE.
REQ-021 INIT writes zero to one word per cycle, address 0 up to DEPTH-1, then goes to IDLE; INIT therefore lasts exactly DEPTH cycles.
REQ-022 clr_busy is 1 exactly when the FSM is in INIT.
REQ-023 In IDLE, clr_start=1 moves the FSM to INIT and the clear restarts at address 0; any request presented in that same cycle is still accepted.
REQ-024 clr_start is ignored while the FSM is in INIT.
REQ-025 An accepted write with req_addr < DEPTH updates only the bytes whose req_be bit is 1; all other bytes keep their value.
REQ-026 A write with req_be = 0 leaves memory unchanged and is not an error.
REQ-027 An accepted read produces rsp_valid=1 exactly RD_LAT cycles after acceptance; there is no response backpressure.
REQ-028 Response order is request order.
REQ-029 Read data reflects every write accepted in an earlier cycle; a write in cycle N is visible to a read accepted in cycle N+1.
REQ-030 For an in-range read, rsp_err is 0 and rsp_rdata is the stored word.
REQ-031 For a read with req_addr >= DEPTH, rsp_err is 1 and rsp_rdata is 0.
REQ-032 A write with req_addr >= DEPTH is dropped and memory is unchanged.
REQ-033 err_cnt increments by 1 on each accepted out-of-range request (read or write) and saturates at 255.
REQ-034 Reads already in the pipeline when INIT starts still complete, with their original latency and the data they sampled.
REQ-035 Accepted writes never produce a response.
REQ-036 When rsp_valid is 0, rsp_rdata and rsp_err are 0.

Reset
REQ-037 While rst_n = 0: FSM = INIT with clear address 0, req_ready = 0, clr_busy = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, err_cnt = 0, and the read pipeline is emptied.
REQ-038 Array contents are not reset directly; the INIT pass that starts when rst_n is released zeroes them, so the first accepted request occurs DEPTH cycles after release.
REQ-039 Reset asserted mid-clear or mid-read discards all in-flight responses; no rsp_valid pulse is produced from work started before the reset.

Verification
REQ-040 Release reset with defaults -> clr_busy is high for 48 cycles, then req_ready rises; a read of address 5 returns 0, rsp_err = 0, 2 cycles after acceptance.
REQ-041 Write 0xDEADBEEF to address 3 with be = 0xF, then write 0x11223344 to address 3 with be = 0x5, then read address 3 -> rdata = 0xDE22BE44.
REQ-042 Back-to-back reads of addresses 0, 1, 2 in consecutive cycles, with RD_LAT = 4 -> three consecutive rsp_valid pulses, in order, the first 4 cycles after the first acceptance.
REQ-043 Read address 50 and write address 63 (DEPTH = 48) -> the read response has rsp_err = 1 and rdata = 0; memory is unchanged; err_cnt = 2; 300 further bad requests -> err_cnt = 255.
REQ-044 Issue a read, then clr_start in the next cycle -> the read returns its pre-clear data; req_ready is 0 for 48 cycles; afterwards every address reads 0.
REQ-045 Drop rst_n with 2 reads in flight -> no rsp_valid pulse occurs; all outputs take their REQ-037 values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/param_mem.sv
// Byte-writable word memory with a fixed-latency read pipeline, a clear engine
// that zeroes every word after reset or on request, and an out-of-range counter.
module param_mem #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 48,
    parameter int unsigned ADDR_W = $clog2(DEPTH),
    parameter int unsigned RD_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    input  logic                  clr_start,
    output logic                  clr_busy,
    output logic [7:0]            err_cnt
);

    localparam int unsigned BE_W = DATA_W / 8;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    typedef struct packed {
        logic              valid;
        logic              err;
        logic [DATA_W-1:0] data;
    } rsp_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_clr_addr;
    logic [ADDR_W-1:0]   w_clr_addr_nxt;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    rsp_t                r_pipe [RD_LAT];
    rsp_t                w_rsp_in;
    logic [7:0]          r_err_cnt;
    logic                w_accept;
    logic                w_in_range;

    assign req_ready  = (r_state == ST_IDLE);
    assign clr_busy   = (r_state == ST_INIT);
    assign w_accept   = req_valid && req_ready;
    assign w_in_range = (32'(req_addr) < DEPTH);

    // State register and clear address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_INIT;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
        end
    end

    // Next state: INIT walks every word once, IDLE restarts the walk on clr_start.
    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        case (r_state)
            ST_INIT: begin
                if (r_clr_addr == ADDR_W'(DEPTH - 1)) begin
                    w_state_nxt    = ST_IDLE;
                    w_clr_addr_nxt = '0;
                end else begin
                    w_clr_addr_nxt = r_clr_addr + ADDR_W'(1);
                end
            end
            ST_IDLE: begin
                if (clr_start) begin
                    w_state_nxt    = ST_INIT;
                    w_clr_addr_nxt = '0;
                end
            end
            default: begin
                w_state_nxt    = ST_INIT;
                w_clr_addr_nxt = '0;
            end
        endcase
    end

    // Storage array: the clear pass owns the write port while in INIT.
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_mem[r_clr_addr] <= '0;
        end else if (w_accept && req_wr && w_in_range) begin
            for (int b = 0; b < int'(BE_W); b++) begin
                if (req_be[b]) begin
                    r_mem[req_addr][b*8 +: 8] <= req_wdata[b*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        w_rsp_in       = '0;
        w_rsp_in.valid = w_accept && !req_wr;
        w_rsp_in.err   = w_accept && !req_wr && !w_in_range;
        if (w_accept && !req_wr && w_in_range) begin
            w_rsp_in.data = r_mem[req_addr];
        end
    end

    // Read pipeline: data is sampled at acceptance, so a later clear cannot alter it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < int'(RD_LAT); s++) begin
                r_pipe[s] <= '0;
            end
        end else begin
            r_pipe[0] <= w_rsp_in;
            for (int s = 1; s < int'(RD_LAT); s++) begin
                r_pipe[s] <= r_pipe[s-1];
            end
        end
    end

    assign rsp_valid = r_pipe[RD_LAT-1].valid;
    assign rsp_err   = r_pipe[RD_LAT-1].err;
    assign rsp_rdata = r_pipe[RD_LAT-1].data;

    // Saturating out-of-range request counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (w_accept && !w_in_range && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_param_mem.sv
// Checks param_mem at read latencies 2 and 4 against a word-array model with a
// per-edge history of expected read responses.
module tb_param_mem;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_wr;
    logic [5:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        clr_start;

    logic        rdy2, rv2, re2, busy2;
    logic [31:0] rd2;
    logic [7:0]  ec2;
    logic        rdy4, rv4, re4, busy4;
    logic [31:0] rd4;
    logic [7:0]  ec4;

    param_mem u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy2),
        .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rv2), .rsp_rdata(rd2), .rsp_err(re2),
        .clr_start(clr_start), .clr_busy(busy2), .err_cnt(ec2)
    );

    param_mem #(.RD_LAT(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy4),
        .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rv4), .rsp_rdata(rd4), .rsp_err(re4),
        .clr_start(clr_start), .clr_busy(busy4), .err_cnt(ec4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;

    // Reference model state
    logic [31:0] m_mem [48];
    int          m_init_left;
    int          m_err;
    int          n;
    logic        hv [16];
    logic [31:0] hd [16];
    logic        he [16];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_init_left = 48;
        m_err       = 0;
        for (int i = 0; i < 48; i++) m_mem[i] = '0;
        for (int i = 0; i < 16; i++) begin
            hv[i] = 1'b0; hd[i] = '0; he[i] = 1'b0;
        end
    endtask

    task automatic check_outputs();
        logic exp_rdy;
        int   i2, i4;
        exp_rdy = (m_init_left == 0);
        i2 = (n - 1) & 15;
        i4 = (n - 3) & 15;
        chk("ready_lat2", 64'(rdy2), 64'(exp_rdy));
        chk("ready_lat4", 64'(rdy4), 64'(exp_rdy));
        chk("busy_lat2", 64'(busy2), 64'(!exp_rdy));
        chk("busy_lat4", 64'(busy4), 64'(!exp_rdy));
        chk("errcnt_lat2", 64'(ec2), 64'(m_err));
        chk("errcnt_lat4", 64'(ec4), 64'(m_err));
        chk("rsp_valid_lat2", 64'(rv2), 64'(hv[i2]));
        chk("rsp_rdata_lat2", 64'(rd2), 64'(hd[i2]));
        chk("rsp_err_lat2", 64'(re2), 64'(he[i2]));
        chk("rsp_valid_lat4", 64'(rv4), 64'(hv[i4]));
        chk("rsp_rdata_lat4", 64'(rd4), 64'(hd[i4]));
        chk("rsp_err_lat4", 64'(re4), 64'(he[i4]));
    endtask

    // One clock: apply the memory rules to the current inputs, then compare after the edge.
    task automatic cycle();
        int a;
        logic inr;
        n++;
        hv[n & 15] = 1'b0; hd[n & 15] = '0; he[n & 15] = 1'b0;
        if (rst_n) begin
            if (m_init_left == 0) begin
                if (req_valid) begin
                    a   = int'(req_addr);
                    inr = (a < 48);
                    if (!inr && m_err < 255) m_err++;
                    if (!req_wr) begin
                        hv[n & 15] = 1'b1;
                        he[n & 15] = !inr;
                        hd[n & 15] = inr ? m_mem[a] : 32'h0;
                    end else if (inr) begin
                        for (int b = 0; b < 4; b++)
                            if (req_be[b]) m_mem[a][b*8 +: 8] = req_wdata[b*8 +: 8];
                    end
                end
                if (clr_start) begin
                    m_init_left = 48;
                    for (int i = 0; i < 48; i++) m_mem[i] = '0;
                end
            end else begin
                m_init_left--;
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic drv(input logic v, input logic w, input int a, input logic [31:0] d,
                       input logic [3:0] be, input logic c);
        req_valid = v;
        req_wr    = w;
        req_addr  = 6'(a);
        req_wdata = d;
        req_be    = be;
        clr_start = c;
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 0, 32'h0, 4'h0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        n = 100;
        m_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        repeat (2) cycle();
        rst_n = 1'b1;

        // Initial clear pass, then a read of a zeroed word
        repeat (48) cycle();
        drv(1'b1, 1'b0, 5, 32'h0, 4'h0, 1'b0);
        cycle();
        idle();
        cycle();
        chk("req040_valid", 64'(rv2), 64'd1);
        chk("req040_rdata", 64'(rd2), 64'd0);
        cycle();

        // Byte-enable merge
        drv(1'b1, 1'b1, 3, 32'hDEADBEEF, 4'hF, 1'b0); cycle();
        drv(1'b1, 1'b1, 3, 32'h11223344, 4'h5, 1'b0); cycle();
        drv(1'b1, 1'b0, 3, 32'h0, 4'h0, 1'b0); cycle();
        idle(); cycle();
        chk("req041_rdata", 64'(rd2), 64'hDE22BE44);
        drv(1'b1, 1'b1, 9, 32'hCAFEF00D, 4'h0, 1'b0); cycle();
        drv(1'b1, 1'b0, 9, 32'h0, 4'h0, 1'b0); cycle();
        idle(); repeat (3) cycle();

        // Back-to-back reads, checked at both latencies
        drv(1'b1, 1'b1, 0, 32'h000000A0, 4'hF, 1'b0); cycle();
        drv(1'b1, 1'b1, 1, 32'h000000A1, 4'hF, 1'b0); cycle();
        drv(1'b1, 1'b1, 2, 32'h000000A2, 4'hF, 1'b0); cycle();
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 1'b0, i, 32'h0, 4'h0, 1'b0);
            cycle();
        end
        idle(); cycle();
        chk("req042_first_valid", 64'(rv4), 64'd1);
        chk("req042_first_rdata", 64'(rd4), 64'hA0);
        repeat (4) cycle();

        // Out-of-range requests and counter saturation
        drv(1'b1, 1'b0, 50, 32'h0, 4'h0, 1'b0); cycle();
        drv(1'b1, 1'b1, 63, 32'hFFFFFFFF, 4'hF, 1'b0); cycle();
        idle(); repeat (3) cycle();
        chk("req043_errcnt2", 64'(ec2), 64'd2);
        for (int i = 0; i < 300; i++) begin
            drv(1'b1, 1'(i % 2), 48 + (i % 16), $urandom, 4'(i), 1'b0);
            cycle();
        end
        idle(); repeat (4) cycle();
        chk("req043_errcnt_sat", 64'(ec2), 64'd255);

        // Read just before a clear keeps its pre-clear data
        drv(1'b1, 1'b1, 7, 32'h5A5A5A5A, 4'hF, 1'b0); cycle();
        drv(1'b1, 1'b0, 7, 32'h0, 4'h0, 1'b0); cycle();
        drv(1'b0, 1'b0, 0, 32'h0, 4'h0, 1'b1); cycle();
        chk("req044_preclear_rdata", 64'(rd2), 64'h5A5A5A5A);
        idle();
        repeat (48) cycle();
        for (int a = 0; a < 48; a++) begin
            drv(1'b1, 1'b0, a, 32'h0, 4'h0, 1'b0);
            cycle();
        end
        idle(); repeat (5) cycle();

        // Reset with reads in flight: outputs clear without a clock edge
        drv(1'b1, 1'b0, 1, 32'h0, 4'h0, 1'b0); cycle();
        drv(1'b1, 1'b0, 2, 32'h0, 4'h0, 1'b0); cycle();
        rst_n = 1'b0;
        m_reset();
        #1;
        check_outputs();
        chk("req045_rsp_valid4", 64'(rv4), 64'd0);
        idle();
        repeat (3) cycle();
        rst_n = 1'b1;
        repeat (60) cycle();

        // Randomized traffic with occasional clears
        for (int i = 0; i < 1500; i++) begin
            drv(1'(($urandom % 4) != 0), 1'($urandom % 2),
                (($urandom % 4) != 0) ? int'($urandom_range(0, 47)) : int'($urandom_range(0, 63)),
                $urandom, 4'($urandom), 1'(($urandom % 128) == 0));
            cycle();
        end
        idle(); repeat (6) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
